// File: rtl/snake_direction_queue_pkg.sv
// Shared definitions for the snake direction queue: heading encoding,
// FIFO sizing limits and the reversal test used across the game logic.
package snake_direction_queue_pkg;

    // Heading encoding: 0 up, 1 right, 2 down, 3 left.
    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_e;

    // Largest supported pending-turn queue; pointers are sized for it.
    localparam int MAX_QUEUE_DEPTH = 4;
    localparam int PTR_W           = 2;
    // Occupancy counter must hold 0..MAX_QUEUE_DEPTH.
    localparam int COUNT_W         = 3;

    // Opposite headings differ only in the upper encoding bit
    // (up/down = 0/2, right/left = 1/3).
    function automatic logic is_reverse(input logic [1:0] a, input logic [1:0] b);
        return (a ^ b) == 2'b10;
    endfunction

endpackage

// File: rtl/direction_fifo.sv
// Circular FIFO of 2-bit headings with an explicit occupancy counter.
// Pointers wrap modulo DEPTH. The head and tail entries are visible
// combinationally so the caller can commit and compare in the same cycle.
module direction_fifo
    import snake_direction_queue_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               srst,
    input  logic               flush,
    input  logic               push,
    input  logic               pop,
    input  logic [1:0]         din,
    output logic [COUNT_W-1:0] count,
    output logic [1:0]         head,
    output logic [1:0]         tail
);

    localparam logic [PTR_W-1:0]   LAST_PTR   = PTR_W'(DEPTH - 1);
    localparam logic [COUNT_W-1:0] FULL_COUNT = COUNT_W'(DEPTH);

    // Storage is always sized for the maximum depth so a PTR_W-bit pointer
    // indexes it exactly; entries at or above DEPTH are never addressed.
    logic [1:0]         mem_q [MAX_QUEUE_DEPTH];
    logic [1:0]         mem_d [MAX_QUEUE_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               push_ok;
    logic               pop_ok;
    logic [PTR_W-1:0]   tail_ptr;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Qualify requests: never pop an empty queue, never overwrite a full
    // queue unless the head leaves in the same cycle.
    always_comb begin
        pop_ok  = pop && (count_q != '0);
        push_ok = push && ((count_q != FULL_COUNT) || pop_ok);
    end

    // Next-state for pointers, occupancy and storage.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = next_ptr(wr_ptr_q);
            end
            if (pop_ok) begin
                rd_ptr_d = next_ptr(rd_ptr_q);
            end
            if (push_ok && !pop_ok) begin
                count_d = count_q + COUNT_W'(1);
            end else if (pop_ok && !push_ok) begin
                count_d = count_q - COUNT_W'(1);
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < MAX_QUEUE_DEPTH; i++) begin
                mem_q[i] <= 2'd0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            for (int i = 0; i < MAX_QUEUE_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // The newest entry sits one slot behind the write pointer.
    always_comb begin
        tail_ptr = (wr_ptr_q == '0) ? LAST_PTR : wr_ptr_q - PTR_W'(1);
        head     = mem_q[rd_ptr_q];
        tail     = mem_q[tail_ptr];
        count    = count_q;
    end

endmodule

// File: rtl/snake_direction_queue.sv
// Direction change queue for the snake game. Takes debounced button pulses,
// filters out repeats and reversals against the most recent pending heading,
// buffers legal turns and commits one per movement tick.
module snake_direction_queue
    import snake_direction_queue_pkg::*;
#(
    parameter int         QUEUE_DEPTH = 2,   // legal range 1..4
    parameter logic [1:0] RESET_DIR   = 2'd1
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       GameActive,
    input  logic       Tick,
    input  logic       UpPress,
    input  logic       RightPress,
    input  logic       DownPress,
    input  logic       LeftPress,
    output logic [1:0] Direction,
    output logic       Turned,
    output logic [2:0] Pending,
    output logic       Dropped
);

    localparam logic [COUNT_W-1:0] FULL_COUNT = COUNT_W'(QUEUE_DEPTH);

    logic [1:0]         direction_q, direction_d;
    logic               turned_q, turned_d;
    logic               dropped_q, dropped_d;

    logic               press_any;
    logic [1:0]         cand;
    logic [1:0]         ref_dir;
    logic               cand_legal;
    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic [COUNT_W-1:0] fifo_count;
    logic [1:0]         fifo_head;
    logic [1:0]         fifo_tail;

    // Fixed-priority press select: Up > Right > Down > Left.
    always_comb begin
        press_any = UpPress | RightPress | DownPress | LeftPress;
        cand      = DIR_LEFT;
        if (UpPress) begin
            cand = DIR_UP;
        end else if (RightPress) begin
            cand = DIR_RIGHT;
        end else if (DownPress) begin
            cand = DIR_DOWN;
        end
    end

    // Accept/reject: compare against the last queued turn, or the committed
    // heading when nothing is queued, so chained double-taps stay legal.
    always_comb begin
        ref_dir    = (fifo_count != '0) ? fifo_tail : direction_q;
        cand_legal = press_any && (cand != ref_dir) && !is_reverse(cand, ref_dir);
        fifo_full  = (fifo_count == FULL_COUNT);
        fifo_pop   = GameActive && Tick && (fifo_count != '0);
        fifo_push  = GameActive && cand_legal && (!fifo_full || fifo_pop);
    end

    // Next committed heading and the single-cycle status pulses.
    always_comb begin
        direction_d = fifo_pop ? fifo_head : direction_q;
        turned_d    = fifo_pop;
        dropped_d   = GameActive && cand_legal && fifo_full && !fifo_pop;
    end

    // Output registers; reset wins over every other input.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            direction_q <= RESET_DIR;
            turned_q    <= 1'b0;
            dropped_q   <= 1'b0;
        end else begin
            direction_q <= direction_d;
            turned_q    <= turned_d;
            dropped_q   <= dropped_d;
        end
    end

    direction_fifo #(
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk   (Clock),
        .srst  (Reset),
        .flush (!GameActive),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (cand),
        .count (fifo_count),
        .head  (fifo_head),
        .tail  (fifo_tail)
    );

    assign Direction = direction_q;
    assign Turned    = turned_q;
    assign Dropped   = dropped_q;
    assign Pending   = fifo_count;

endmodule
